puf_resp_capture: RTL and testbench

//  Multi-channel arbiter response capture for the PUF core. Per channel:
//  - registers the arbiter data bit;
//  - repeats the measurement SAMPLES times and majority-votes the result;
//  - flags channels that did not give the same bit every time.

---
 rtl/puf_resp_capture.sv | 105 ++++++++++
 tb/tb_puf_resp_capture.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/puf_resp_capture.sv
// Multi-channel PUF arbiter response capture: repeated sampling, per-channel majority vote and instability flags.
// Optional macro PUF_SYNC2_EN adds a second input register stage (all latencies +1 clk).
module puf_resp_capture #(
  parameter int WIDTH   = 8,
  parameter int SAMPLES = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             sample,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] unstable,
  output logic             resp_valid,
  input  logic             resp_ready
);

  localparam int CNT_W = $clog2(SAMPLES + 1);
  localparam logic [CNT_W-1:0] SAMP_C = CNT_W'(SAMPLES);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(SAMPLES / 2);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] issued, taken;
  logic [CNT_W-1:0] ones [WIDTH];
  logic [WIDTH-1:0] data_r, data_q;
  logic             stb_r, stb_q;
  logic             stb_gate, enter, done;

  assign stb_gate = sample && (state == COLLECT) && (issued < SAMP_C);
  assign enter    = (state == IDLE) && start;
  assign done     = (state == COLLECT) && (taken == SAMP_C);

`ifdef PUF_SYNC2_EN
  logic [WIDTH-1:0] data_r2;
  logic             stb_r2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r2 <= '0;
      stb_r2  <= 1'b0;
    end else begin
      data_r2 <= data_r;
      stb_r2  <= stb_r;
    end
  end

  assign data_q = data_r2;
  assign stb_q  = stb_r2;
`else
  assign data_q = data_r;
  assign stb_q  = stb_r;
`endif

  always_comb begin
    state_d    = state;
    busy       = (state != IDLE);
    resp_valid = (state == HOLD);
    case (state)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (taken == SAMP_C) state_d = HOLD;
      HOLD:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_r   <= '0;
      stb_r    <= 1'b0;
      issued   <= '0;
      taken    <= '0;
      resp     <= '0;
      unstable <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) ones[i] <= '0;
    end else begin
      state  <= state_d;
      data_r <= data;
      stb_r  <= stb_gate;
      if (enter) begin
        issued <= '0;
        taken  <= '0;
        for (int unsigned i = 0; i < WIDTH; i++) ones[i] <= '0;
      end else begin
        if (stb_gate) issued <= issued + CNT_W'(1);
        if (stb_q) begin
          taken <= taken + CNT_W'(1);
          for (int unsigned i = 0; i < WIDTH; i++)
            ones[i] <= ones[i] + CNT_W'(data_q[i]);
        end
      end
      // ones[] is final here: every accepted strobe has drained through the pipe
      if (done) begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          resp[i]     <= (ones[i] > HALF_C);
          unstable[i] <= (ones[i] != '0) && (ones[i] != SAMP_C);
        end
      end
    end
  end

endmodule

// File: tb/tb_puf_resp_capture.sv
// Scoreboard bench for puf_resp_capture: random runs plus directed stable/majority/overrun/reset cases.
module tb_puf_resp_capture;

  localparam int W = 8;
  localparam int S = 5;

  logic         clk = 1'b0;
  logic         rst_n, sample, start, resp_ready;
  logic [W-1:0] data;
  logic         busy, resp_valid;
  logic [W-1:0] resp, unstable;

  int errors = 0;
  int checks = 0;

  logic [15:0] expq [$];
  logic [7:0]  pat [7];

  puf_resp_capture #(.WIDTH(W), .SAMPLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .sample(sample), .start(start),
    .busy(busy), .resp(resp), .unstable(unstable),
    .resp_valid(resp_valid), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: per-channel ones count over the first S samples, then majority / disagreement.
  function automatic logic [15:0] model();
    logic [7:0] r, u;
    r = '0;
    u = '0;
    for (int c = 0; c < W; c++) begin
      int n;
      n = 0;
      for (int k = 0; k < S; k++) n += int'(pat[k][c]);
      r[c] = (2 * n > S);
      u[c] = (n != 0) && (n != S);
    end
    return {u, r};
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy === 1'b1 && t < 60) begin
      tick();
      t++;
    end
    if (t >= 60) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_txn(input int n, input int max_gap, input int hold, input bit latchk);
    logic [15:0] e;
    int t;
    e = model();
    wait_idle();
    resp_ready = 1'b0;
    start = 1'b1; sample = 1'b1; data = 8'($urandom);
    tick();
    start = 1'b0; sample = 1'b0;
    chk("busy_collect", 32'(busy), 32'd1);
    for (int k = 0; k < n; k++) begin
      int g;
      g = $urandom_range(0, max_gap);
      for (int j = 0; j < g; j++) begin
        sample = 1'b0; data = 8'($urandom);
        tick();
      end
      sample = 1'b1; data = pat[k];
      if (k == S - 1) expq.push_back(e);
      tick();
    end
    sample = 1'b0; data = 8'($urandom);
    if (latchk) begin
      chk("lat_e0", 32'(resp_valid), 32'd0);
      tick();
      chk("lat_e1", 32'(resp_valid), 32'd0);
`ifdef PUF_SYNC2_EN
      tick();
      chk("lat_e2s", 32'(resp_valid), 32'd0);
`endif
      tick();
      chk("lat_valid", 32'(resp_valid), 32'd1);
    end else begin
      t = 0;
      while (resp_valid !== 1'b1 && t < 40) begin
        tick();
        t++;
      end
      chk("valid_seen", 32'(resp_valid), 32'd1);
    end
    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom); sample = 1'($urandom); data = 8'($urandom);
      tick();
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_resp", 32'({unstable, resp}), 32'(e));
    end
    start = 1'b1; sample = 1'b0; resp_ready = 1'b1;
    tick();
    start = 1'b0; resp_ready = 1'b0;
    chk("release_valid", 32'(resp_valid), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);
    tick();
    chk("start_at_return_ignored", 32'(busy), 32'd0);
    chk("resp_kept", 32'({unstable, resp}), 32'(e));
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        logic [15:0] e;
        e = expq.pop_front();
        chk("sb_resp", 32'(resp), 32'(e[7:0]));
        chk("sb_unstable", 32'(unstable), 32'(e[15:8]));
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; sample = 1'b1; resp_ready = 1'b0; data = 8'hFF;
    tick();
    tick();
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_unstable", 32'(unstable), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; start = 1'b0; sample = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) pat[k] = 8'hA5;
    run_txn(S, 0, 10, 1'b1);

    pat[0] = 8'hA5; pat[1] = 8'hA5; pat[2] = 8'h5A; pat[3] = 8'hA5; pat[4] = 8'h5A;
    run_txn(S, 0, 2, 1'b1);

    pat[0] = 8'h0F; pat[1] = 8'h0F; pat[2] = 8'h0F; pat[3] = 8'hF0;
    pat[4] = 8'h0F; pat[5] = 8'hF0; pat[6] = 8'hF0;
    run_txn(7, 0, 1, 1'b0);

    // mid-run reset discards in-flight samples and clears outputs
    wait_idle();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample = 1'b1; data = 8'hFF;
      tick();
    end
    sample = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_resp", 32'({unstable, resp}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    tick();
    for (int k = 0; k < 7; k++) pat[k] = 8'h3C;
    run_txn(S, 0, 0, 1'b1);

    for (int r = 0; r < 25; r++) begin
      logic [7:0] base;
      base = 8'($urandom);
      for (int k = 0; k < 7; k++) begin
        logic [7:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) m[b] = ($urandom_range(0, 3) == 0);
        pat[k] = base ^ m;
      end
      run_txn($urandom_range(S, 7), 2, $urandom_range(0, 4), 1'b0);
    end

    tick();
    chk("sb_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
